// File: rtl/boot_loader_pkg.sv
// Shared types and frame-layout constants for the instruction-memory boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Collects payload bytes LSB-first into a 32-bit word; word_full_o marks the
// accepted byte that completes the word.
module word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  assign word_o      = word_q;
  assign word_full_o = byte_en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

  // Index wraps to 0 after the last byte, so the next word starts cleanly.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (byte_en_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      idx_q                        <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a framed byte stream (length, payload, checksum) into instruction ROM
// and holds the core in reset until a verified image is present.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 1024
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;

  logic        accept;
  logic        restart_ok;
  logic        byte_en;
  logic        word_full;
  logic [31:0] word;

  assign accept     = rx_valid && rx_ready;
  assign restart_ok = restart && ((state_q == S_DONE) || (state_q == S_ERR));
  assign byte_en    = accept && (state_q == S_DATA);

  word_assembler u_asm (
    .clk_i       (CLOCK_50),
    .clear_i     (reset || restart_ok),
    .byte_en_i   (byte_en),
    .byte_i      (rx_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    rx_ready = 1'b0;
    imem_we  = 1'b0;
    unique case (state_q)
      S_LEN0: begin
        rx_ready = 1'b1;
        if (accept) begin
          len_d   = {8'h00, rx_data};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (accept) begin
          len_d = {rx_data, len_q[7:0]};
          if (len_d > MAX_LEN)     state_d = S_ERR;
          else if (len_d == '0)    state_d = S_CSUM;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (accept) begin
          sum_d = sum_q + rx_data;
          if (word_full) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_d == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart_ok) begin
          state_d = S_LEN0;
          len_d   = '0;
          wcnt_d  = '0;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      default: state_d = S_LEN0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign core_reset = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

endmodule

// File: doc/boot_loader.md
# boot_loader

Front-end stage that fills the core's instruction memory before execution starts. It accepts a framed byte stream (length, payload, checksum) and assembles little-endian 32-bit words. It issues one write per word to instruction ROM at consecutive word-aligned addresses, and holds the RISC-V core in reset until a complete, checksum-valid image is loaded. It replaces bench-side forcing of ROM address/write-data with a synthesizable load path between the serial receiver and the core's instruction ROM write port.

## Interface
- ADDR_W, 12: instruction-memory byte-address width (4096 bytes).
- MAX_WORDS, 1024: largest accepted word count; must be ≤ 2^(ADDR_W-2).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted on an edge where rx_valid && rx_ready.
- restart  in  1  single-cycle request to reload; honoured only in DONE or ERR.
- imem_we  out  1  one-cycle instruction-ROM write strobe.
- imem_addr  out  ADDR_W  byte address; low two bits are always 0.
- imem_wdata  out  32  word to write.
- core_reset  out  1  high holds the core in reset.
- done  out  1  image loaded and verified.
- error  out  1  bad length or checksum.

## Operation
- Frame format:
  - LEN0, LEN1: word count N, little-endian 16-bit.
  - 4·N payload bytes: each word is sent LSB first.
  - CSUM: 8-bit sum, mod 256, of payload bytes only.
- States:
  - S_LEN0 → S_LEN1 after one accepted byte.
  - S_LEN1 → S_ERR if N > MAX_WORDS; S_CSUM if N == 0; otherwise S_DATA.
  - S_DATA: counts bytes 0..3. After byte 3 is accepted → S_WRITE.
  - S_WRITE, one cycle: imem_we=1. Then → S_DATA if more words remain, else S_CSUM.
  - S_CSUM: on the accepted byte, → S_DONE if it equals the running sum, else S_ERR.
  - S_DONE and S_ERR: on restart → S_LEN0, clearing the word count, address and sum.
- rx_ready=1 only in S_LEN0, S_LEN1, S_DATA and S_CSUM.
- Word assembly: byte k fills bits [8k+7:8k]. The running sum adds each payload byte as it is accepted.
- Addresses: imem_addr starts at 0 and advances by 4 after each write. It never wraps, because MAX_WORDS bounds it.
- Status outputs:
  - core_reset=1 in every state except S_DONE.
  - done=1 only in S_DONE.
  - error=1 only in S_ERR.

## Timing
- Reset values:
  - state=S_LEN0, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, done=0, error=0, sum=0, counters=0.
- Write latency: imem_we is asserted in the cycle immediately after the edge that accepts a word's 4th byte. imem_addr and imem_wdata are stable for that whole cycle.
- Back-pressure: during S_WRITE, a byte held on rx_valid is not consumed. It is accepted on the first edge after S_WRITE, so one cycle is lost per word.
- done and core_reset change on the edge that accepts a matching CSUM byte:
  - From the next cycle, done=1 and core_reset=0.
- The length check happens on the edge that accepts LEN1. From the next cycle, error=1 and no writes are issued.
- A restart pulse outside S_DONE/S_ERR is ignored.
- reset asserted at any time, including mid-word or during S_WRITE:
  - Returns all registers to their reset values on that edge.
  - imem_we is 0 from the next cycle.
  - A partial word is discarded.
  - reset has priority over restart and rx_valid.
- Throughput: 5 cycles per word when rx_valid is held high.

## Structure
- Package boot_loader_pkg holds:
  - state enum (S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR);
  - the frame-layout constants (BYTES_PER_WORD=4, LEN_BYTES=2).
- One sub-module, word_assembler:
  - 2-bit byte index and 32-bit shift/insert register;
  - word_full flag;
  - clear input, driven from reset/restart.
- The FSM, address counter, word counter and checksum live in boot_loader.

## Test plan
- Two words, valid image. Stream 02 00 93 00 00 00 13 01 10 00 B7 with rx_valid held high.
  - Writes (0x000, 0x00000093) then (0x004, 0x00100113).
  - One cycle after B7 is accepted: done=1, core_reset=0.
- Bad checksum. Same stream with final byte B8.
  - Both writes still occur; then error=1, core_reset=1, done=0.
  - A restart pulse followed by the valid stream reaches done=1, with rewrites starting at address 0.
- Zero-length image. Stream 00 00 00.
  - No imem_we; done=1.
- Oversize image. LEN bytes 01 04 (N=1025).
  - error=1 the cycle after 04 is accepted; the following bytes are not accepted; no imem_we.
- Reset mid-load. Assert reset after 2 payload bytes of word 1 (word 0 already written).
  - Next cycle: imem_addr=0, core_reset=1, no further write for the partial word.
  - A fresh full frame then loads correctly.
- Back-pressure and valid gaps. Insert random rx_valid=0 gaps.
  - rx_ready=0 exactly during S_WRITE.
  - Written words and addresses are identical to the gap-free run.
